// File: rtl/key_pio_pkg.sv
// Shared constants for the debounced key PIO: register addresses and counter sizing.
package key_pio_pkg;

   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_DATA  = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_SYNC  = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_MASK  = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGE  = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_RISE  = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_FALL  = 3'd5;
   localparam logic [ADDR_W-1:0] ADDR_LEVEL = 3'd6;

   // Counter must hold 0..cycles; a bypassed debouncer still gets a minimum 1-bit width.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles == 0) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/key_pio_db_chan.sv
// One key channel: 2-flop synchroniser followed by a stable-count debouncer.
module key_pio_db_chan
   import key_pio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_sync,
   output logic o_stable
);

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

   logic r_meta;
   logic r_sync;
   logic r_stable;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_raw;
         r_sync <= r_meta;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_stable <= 1'b0;
            else          r_stable <= r_sync;
         end
      end else begin : g_debounce
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
         logic [CNT_W-1:0] r_cnt;

         // Any sample agreeing with the debounced value restarts the count.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_cnt    <= '0;
               r_stable <= 1'b0;
            end else if (r_sync == r_stable) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_stable <= r_sync;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
      end
   endgenerate

   assign o_sync   = r_sync;
   assign o_stable = r_stable;

endmodule

// File: rtl/key_pio_db.sv
// Debounced key PIO Avalon-MM slave with edge capture and masked level IRQ.
// Define KEY_PIO_LEVEL_IRQ_EN to add the level_mode register at address 6.
module key_pio_db
   import key_pio_pkg::*;
#(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 16,
   parameter logic [WIDTH-1:0] RISE_RESET      = '0,
   parameter logic [WIDTH-1:0] FALL_RESET      = '1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq,
   output logic [31:0]       readdata
);

   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_edge_set;
   logic [WIDTH-1:0] w_level_set;
   logic [WIDTH-1:0] w_rd_mux;
   logic             w_wr;

   logic [WIDTH-1:0] r_stable_q;
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge;
   logic [WIDTH-1:0] r_rise_en;
   logic [WIDTH-1:0] r_fall_en;
   logic [31:0]      r_readdata;

   generate
      for (genvar g = 0; g < WIDTH; g++) begin : g_chan
         key_pio_db_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .i_raw    (in_port[g]),
            .o_sync   (w_sync[g]),
            .o_stable (w_stable[g])
         );
      end
      if (WIDTH < 32) begin : g_unused
         logic w_unused_wdata;
         assign w_unused_wdata = ^writedata[31:WIDTH];
      end
   endgenerate

   assign w_wr    = chipselect & ~write_n;
   assign w_wdata = writedata[WIDTH-1:0];
   assign w_clr   = (w_wr && address == ADDR_EDGE) ? w_wdata : '0;

   assign w_edge_set = (w_stable & ~r_stable_q & r_rise_en)
                     | (~w_stable & r_stable_q & r_fall_en)
                     | w_level_set;

`ifdef KEY_PIO_LEVEL_IRQ_EN
   logic [WIDTH-1:0] r_level;

   // Held keys in level mode keep re-asserting capture until released.
   assign w_level_set = r_level & ~w_stable;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          r_level <= '0;
      else if (w_wr && address == ADDR_LEVEL) r_level <= w_wdata;
   end
`else
   assign w_level_set = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stable_q <= '0;
         r_irq_mask <= '0;
         r_edge     <= '0;
         r_rise_en  <= RISE_RESET;
         r_fall_en  <= FALL_RESET;
      end else begin
         r_stable_q <= w_stable;
         // New edges win over a same-cycle clear so no event is dropped.
         r_edge     <= (r_edge & ~w_clr) | w_edge_set;
         if (w_wr && address == ADDR_MASK) r_irq_mask <= w_wdata;
         if (w_wr && address == ADDR_RISE) r_rise_en  <= w_wdata;
         if (w_wr && address == ADDR_FALL) r_fall_en  <= w_wdata;
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (address)
         ADDR_DATA:  w_rd_mux = w_stable;
         ADDR_SYNC:  w_rd_mux = w_sync;
         ADDR_MASK:  w_rd_mux = r_irq_mask;
         ADDR_EDGE:  w_rd_mux = r_edge;
         ADDR_RISE:  w_rd_mux = r_rise_en;
         ADDR_FALL:  w_rd_mux = r_fall_en;
`ifdef KEY_PIO_LEVEL_IRQ_EN
         ADDR_LEVEL: w_rd_mux = r_level;
`endif
         default:    w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_readdata <= '0;
      else          r_readdata <= 32'(w_rd_mux);
   end

   assign readdata = r_readdata;
   assign irq      = |(r_edge & r_irq_mask);

endmodule

// File: tb/tb_key_pio_db.sv
// Directed bench for key_pio_db (WIDTH=4, DEBOUNCE_CYCLES=4); all stimulus and sampling on the falling edge.
module tb_key_pio_db;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic        irq;
   logic [31:0] readdata;

   int n_checks = 0;
   int n_fail   = 0;

   key_pio_db #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .irq        (irq),
      .readdata   (readdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      tick();
      chipselect = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      reset_n = 1'b0; in_port = 4'hF; address = 3'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      repeat (3) tick();
      n_checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: readdata=%h irq=%b expected 0/0", readdata, irq);
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp = (k >= 7) ? 32'hF : 32'h0;
         n_checks++;
         if (readdata !== exp) begin
            n_fail++; $display("FAIL reset_release_cycle%0d: readdata=%h expected %h", k, readdata, exp);
         end
      end
      repeat (3) tick();
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL reset_no_capture: edge=%h irq=%b expected 0/0", readdata, irq);
      end
      rd(3'd4);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL reset_rise_en: got %h expected 0", readdata);
      end
      rd(3'd5);
      n_checks++;
      if (readdata !== 32'hF) begin
         n_fail++; $display("FAIL reset_fall_en: got %h expected f", readdata);
      end
   endtask

   task automatic test_glitch();
      in_port = 4'hE;
      repeat (3) tick();
      in_port = 4'hF;
      address = 3'd0;
      for (int k = 0; k < 12; k++) begin
         tick();
         n_checks++;
         if (readdata !== 32'hF) begin
            n_fail++; $display("FAIL glitch_stable_cycle%0d: got %h expected f", k, readdata);
         end
      end
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL glitch_edge: got %h expected 0", readdata);
      end
   endtask

   task automatic test_press();
      wr(3'd2, 32'h4);
      in_port = 4'hB;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k >= 6) begin
            n_checks++;
            if (irq !== (k == 7)) begin
               n_fail++; $display("FAIL press_irq_cycle%0d: got %b expected %b", k, irq, k == 7);
            end
         end
      end
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h4) begin
         n_fail++; $display("FAIL press_edge: got %h expected 4", readdata);
      end
      wr(3'd3, 32'h4);
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++; $display("FAIL press_w1c_irq: got %b expected 0", irq);
      end
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL press_w1c_edge: got %h expected 0", readdata);
      end
      in_port = 4'hF;
      repeat (10) tick();
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL release_no_rise: edge=%h irq=%b expected 0/0", readdata, irq);
      end
   endtask

   task automatic test_w1c_collision();
      in_port = 4'hD;
      repeat (6) tick();
      wr(3'd3, 32'h2);
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h2) begin
         n_fail++; $display("FAIL collision_edge: got %h expected 2", readdata);
      end
      n_checks++;
      if (irq !== 1'b0) begin
         n_fail++; $display("FAIL collision_masked_irq: got %b expected 0", irq);
      end
      wr(3'd2, 32'hF);
      n_checks++;
      if (irq !== 1'b1) begin
         n_fail++; $display("FAIL unmask_irq: got %b expected 1", irq);
      end
      wr(3'd3, 32'h2);
      in_port = 4'hF;
      repeat (10) tick();
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL collision_cleared: edge=%h irq=%b expected 0/0", readdata, irq);
      end
   endtask

   task automatic test_rise_only();
      wr(3'd4, 32'h1);
      wr(3'd5, 32'h0);
      rd(3'd4);
      n_checks++;
      if (readdata !== 32'h1) begin
         n_fail++; $display("FAIL rise_en_read: got %h expected 00000001", readdata);
      end
      rd(3'd5);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL fall_en_read: got %h expected 0", readdata);
      end
      in_port = 4'hE;
      repeat (8) tick();
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL rise_only_fall_ignored: got %h expected 0", readdata);
      end
      in_port = 4'hF;
      repeat (8) tick();
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h1 || irq !== 1'b1) begin
         n_fail++; $display("FAIL rise_only_capture: edge=%h irq=%b expected 1/1", readdata, irq);
      end
      wr(3'd3, 32'h1);
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h0 || irq !== 1'b0) begin
         n_fail++; $display("FAIL rise_only_w1c: edge=%h irq=%b expected 0/0", readdata, irq);
      end
   endtask

   task automatic test_level();
`ifdef KEY_PIO_LEVEL_IRQ_EN
      wr(3'd6, 32'h8);
      in_port = 4'h7;
      repeat (8) tick();
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h8) begin
         n_fail++; $display("FAIL level_held_capture: got %h expected 8", readdata);
      end
      wr(3'd3, 32'h8);
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h8) begin
         n_fail++; $display("FAIL level_w1c_while_held: got %h expected 8", readdata);
      end
      in_port = 4'hF;
      repeat (8) tick();
      wr(3'd3, 32'h8);
      rd(3'd3);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL level_w1c_after_release: got %h expected 0", readdata);
      end
`else
      wr(3'd6, 32'hF);
      rd(3'd6);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL addr6_absent: got %h expected 0", readdata);
      end
`endif
   endtask

   task automatic test_map_misc();
      wr(3'd7, 32'hF);
      rd(3'd7);
      n_checks++;
      if (readdata !== 32'h0) begin
         n_fail++; $display("FAIL addr7_zero: got %h expected 0", readdata);
      end
      wr(3'd0, 32'h0);
      rd(3'd0);
      n_checks++;
      if (readdata !== 32'hF) begin
         n_fail++; $display("FAIL ro_write_ignored: got %h expected f", readdata);
      end
      rd(3'd2);
      n_checks++;
      if (readdata !== 32'hF) begin
         n_fail++; $display("FAIL mask_read: got %h expected f", readdata);
      end
      in_port = 4'hA;
      repeat (2) tick();
      rd(3'd1);
      n_checks++;
      if (readdata !== 32'hA) begin
         n_fail++; $display("FAIL sync_q_read: got %h expected a", readdata);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_press();
      test_w1c_collision();
      test_rise_only();
      test_level();
      test_map_misc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
